// File: rtl/arm_mem_pkg.sv
// Shared definitions for the instruction/data memory port arbiter.
package arm_mem_pkg;

    // Arbiter states. Only one requester owns the memory port at a time.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    // Encoding of the round-robin history bit.
    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on the memory and flags the edge at which the
// wait reaches MAX_WAIT. MAX_WAIT = 0 disables expiry entirely.
module mem_wait_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    // Count value at which one more wait cycle reaches MAX_WAIT.
    localparam logic [CNT_W-1:0] LAST = CNT_W'((MAX_WAIT == 0) ? 0 : MAX_WAIT - 1);

    logic [CNT_W-1:0] count;

    // Wait-cycle counter: cleared on every grant, advanced on every stalled cycle.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: registers use non-blocking assignments so every flop samples
        // pre-edge values; blocking here would create order-dependent logic.
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = (MAX_WAIT != 0) && enable && (count == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch (I) and the
// MEM-stage data requester (D), with round-robin tie-break, zero-bubble
// back-to-back grants and an optional wait timeout.
module mem_port_arbiter
    import arm_mem_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ready,
    output logic              stall_f,
    output logic              stall_m,
    output logic              busy,
    output logic              timeout_err
);

    arb_state_t state;
    logic       last_grant;

    logic busy_i, busy_d, done, expired, arb_en;
    logic cand_i, cand_d, grant_i, grant_d;

    // Arbitration: eligible requesters minus the one completing at this edge.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        busy_i  = 1'b0;
        busy_d  = 1'b0;
        grant_i = 1'b0;
        grant_d = 1'b0;
        busy_i  = (state == BUSY_I);
        busy_d  = (state == BUSY_D);
        done    = (busy_i || busy_d) && m_ready;
        arb_en  = (state == IDLE) || done;
        cand_i  = i_req && !i_ack && !(busy_i && done);
        cand_d  = d_req && !d_ack && !(busy_d && done);
        if (arb_en) begin
            grant_d = cand_d && (!cand_i || last_grant == GRANT_I);
            grant_i = cand_i && !grant_d;
        end
    end

    mem_wait_timer #(
        .MAX_WAIT(MAX_WAIT)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (grant_i || grant_d),
        .enable ((busy_i || busy_d) && !m_ready),
        .expired(expired)
    );

    // Port FSM: completion/timeout handling plus registered memory request.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: asynchronous reset clears m_req/m_we immediately so an
        // abandoned transaction never keeps driving the memory.
        if (reset) begin
            state       <= IDLE;
            last_grant  <= GRANT_I;
            m_req       <= 1'b0;
            m_we        <= 1'b0;
            m_addr      <= '0;
            m_wdata     <= '0;
            i_ack       <= 1'b0;
            d_ack       <= 1'b0;
            i_rdata     <= '0;
            d_rdata     <= '0;
            timeout_err <= 1'b0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;

            if (done) begin
                if (busy_i) begin
                    i_ack   <= 1'b1;
                    i_rdata <= m_rdata;
                end else begin
                    d_ack <= 1'b1;
                    if (!m_we) begin
                        d_rdata <= m_rdata;
                    end
                end
            end else if (expired) begin
                timeout_err <= 1'b1;
                if (busy_i) begin
                    i_ack   <= 1'b1;
                    i_rdata <= '0;
                end else begin
                    d_ack   <= 1'b1;
                    d_rdata <= '0;
                end
            end

            if (grant_d) begin
                state      <= BUSY_D;
                last_grant <= GRANT_D;
                m_req      <= 1'b1;
                m_we       <= d_we;
                m_addr     <= d_addr;
                m_wdata    <= d_wdata;
            end else if (grant_i) begin
                state      <= BUSY_I;
                last_grant <= GRANT_I;
                m_req      <= 1'b1;
                m_we       <= 1'b0;
                m_addr     <= i_addr;
                m_wdata    <= '0;
            end else if (done || expired) begin
                state <= IDLE;
                m_req <= 1'b0;
                m_we  <= 1'b0;
            end
        end
    end

    assign stall_f = i_req && !i_ack;
    assign stall_m = d_req && !d_ack;
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: table-driven basic cycles,
// directed multi-cycle corner cases and a randomized run against a
// transaction-level memory model.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_req, d_req, d_we;
    logic [AW-1:0] i_addr, d_addr;
    logic [DW-1:0] d_wdata;
    logic          i_ack, d_ack;
    logic [DW-1:0] i_rdata, d_rdata;
    logic          m_req, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata = '0;
    logic          m_ready = 1'b0;
    logic          stall_f, stall_m, busy, timeout_err;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ready(m_ready),
        .stall_f(stall_f), .stall_m(stall_m), .busy(busy), .timeout_err(timeout_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Default memory contents for words never written.
    function automatic logic [31:0] pattern(input logic [31:0] a);
        return a * 32'h9E3779B1 + 32'h0BADF00D;
    endfunction

    // ---------------- memory responder ----------------
    logic [31:0] mem [logic [31:0]];
    bit rand_mode   = 0;
    bit never_ready = 0;
    int fixed_delay = 0;
    int wait_left   = 0;
    bit new_txn     = 1;

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return pattern(a);
    endfunction

    always @(negedge clk) begin
        if (m_req) begin
            if (new_txn) begin
                wait_left = rand_mode ? int'($urandom_range(0, 2)) : fixed_delay;
                new_txn   = 0;
            end
            if (never_ready) m_ready = 1'b0;
            else if (wait_left == 0) m_ready = 1'b1;
            else begin
                m_ready = 1'b0;
                wait_left--;
            end
        end else begin
            new_txn = 1;
            m_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        m_rdata = (m_req && m_ready && !m_we) ? mem_read(m_addr) : $urandom;
    end

    always @(posedge clk) begin
        if (m_req && m_ready) begin
            if (m_we) mem[m_addr] = m_wdata;
            new_txn = 1;
        end
    end

    // ---------------- vector table ----------------
    // exp_ctl = {m_req, m_we, i_ack, d_ack, stall_f, stall_m, busy}
    typedef struct {
        logic        i_req;
        logic [31:0] i_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic [6:0]  exp_ctl;
        logic [31:0] exp_m_addr;
        logic [31:0] exp_m_wdata;
        logic [31:0] exp_i_rdata;
        logic [31:0] exp_d_rdata;
    } vec_t;

    vec_t vecs [9];

    // random-phase state
    logic [31:0] dref [logic [31:0]];
    bit          i_out, d_out, d_cur_we;
    logic [31:0] i_cur, d_cur, d_cur_wd, last_load;
    int          i_age, d_age, i_done, d_done, inv_viol, ack_viol, age_viol;

    initial begin
        int n_acks, ack_cyc, viol, nd;
        logic [5:0] order;
        bit prev_i, prev_d;

        reset = 1'b1;
        i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        mem[32'h100] = 32'hE3A01005;
        mem[32'h104] = 32'hE5912004;
        mem[32'h300] = 32'h12345678;

        vecs[0] = '{1, 32'h100, 0, 0, 32'h0,   32'h0,        7'b0000100, 32'h0,   32'h0,        32'h0,        32'h0};
        vecs[1] = '{1, 32'h100, 0, 0, 32'h0,   32'h0,        7'b1000101, 32'h100, 32'h0,        32'h0,        32'h0};
        vecs[2] = '{1, 32'h100, 0, 0, 32'h0,   32'h0,        7'b0010000, 32'h0,   32'h0,        32'hE3A01005, 32'h0};
        vecs[3] = '{0, 32'h100, 0, 0, 32'h0,   32'h0,        7'b0000000, 32'h0,   32'h0,        32'hE3A01005, 32'h0};
        vecs[4] = '{1, 32'h104, 1, 1, 32'h200, 32'hDEADBEEF, 7'b0000110, 32'h0,   32'h0,        32'hE3A01005, 32'h0};
        vecs[5] = '{1, 32'h104, 1, 1, 32'h200, 32'hDEADBEEF, 7'b1100111, 32'h200, 32'hDEADBEEF, 32'hE3A01005, 32'h0};
        vecs[6] = '{1, 32'h104, 1, 1, 32'h200, 32'hDEADBEEF, 7'b1001101, 32'h104, 32'h0,        32'hE3A01005, 32'h0};
        vecs[7] = '{1, 32'h104, 0, 0, 32'h200, 32'h0,        7'b0010000, 32'h0,   32'h0,        32'hE5912004, 32'h0};
        vecs[8] = '{0, 32'h0,   0, 0, 32'h0,   32'h0,        7'b0000000, 32'h0,   32'h0,        32'hE5912004, 32'h0};

        // Reset state
        #1;
        check("reset_ctl", {m_req, m_we, i_ack, d_ack, busy, timeout_err, stall_f, stall_m}, 8'h00);
        check("reset_data", {m_addr, m_wdata} | {i_rdata, d_rdata}, 64'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;

        // Table: single I read, then D store and I read together
        for (int k = 0; k < 9; k++) begin
            @(posedge clk); #1;
            i_req = vecs[k].i_req; i_addr = vecs[k].i_addr;
            d_req = vecs[k].d_req; d_we = vecs[k].d_we;
            d_addr = vecs[k].d_addr; d_wdata = vecs[k].d_wdata;
            @(negedge clk);
            check($sformatf("vec%0d_ctl", k), {m_req, m_we, i_ack, d_ack, stall_f, stall_m, busy}, vecs[k].exp_ctl);
            if (vecs[k].exp_ctl[6]) begin
                check($sformatf("vec%0d_m_addr", k), m_addr, vecs[k].exp_m_addr);
                check($sformatf("vec%0d_m_wdata", k), m_wdata, vecs[k].exp_m_wdata);
            end
            check($sformatf("vec%0d_i_rdata", k), i_rdata, vecs[k].exp_i_rdata);
            check($sformatf("vec%0d_d_rdata", k), d_rdata, vecs[k].exp_d_rdata);
        end

        // Both requesters held: expect D, I, D, I, D, I
        @(posedge clk); #1;
        i_req = 1; i_addr = 32'h108; d_req = 1; d_we = 0; d_addr = 32'h200;
        n_acks = 0; viol = 0; order = '0; prev_i = 0; prev_d = 0;
        for (int c = 0; c < 60 && n_acks < 6; c++) begin
            @(negedge clk);
            if (i_ack && d_ack) viol++;
            if ((i_ack && prev_i) || (d_ack && prev_d)) viol++;
            prev_i = i_ack; prev_d = d_ack;
            if (i_ack || d_ack) begin
                order[5 - n_acks] = d_ack;
                n_acks++;
                if (n_acks == 6) begin
                    i_req = 0; d_req = 0;
                end
            end
        end
        check("rr_six_acks", n_acks, 6);
        check("rr_order", order, 6'b101010);
        check("rr_ack_one_cycle", viol, 0);
        check("rr_d_rdata", d_rdata, 32'hDEADBEEF);
        check("rr_i_rdata", i_rdata, pattern(32'h108));
        repeat (2) @(posedge clk);

        // D load with three extra wait cycles (just below the timeout)
        fixed_delay = 3;
        @(posedge clk); #1;
        d_req = 1; d_we = 0; d_addr = 32'h300;
        ack_cyc = -1; viol = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (m_req && m_addr !== 32'h300) viol++;
            if (d_ack) begin
                ack_cyc = c;
                d_req = 0;
                break;
            end
        end
        check("wait_ack_cycle", ack_cyc, 5);
        check("wait_addr_stable", viol, 0);
        check("wait_d_rdata", d_rdata, 32'h12345678);
        check("wait_no_timeout", timeout_err, 1'b0);
        fixed_delay = 0;
        repeat (2) @(posedge clk);

        // Randomized traffic against the transaction-level model
        rand_mode = 1;
        i_out = 0; d_out = 0; i_done = 0; d_done = 0;
        inv_viol = 0; ack_viol = 0; age_viol = 0;
        last_load = 32'h12345678;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (m_we && !m_req) inv_viol++;
            if (stall_f !== (i_req && !i_ack)) inv_viol++;
            if (stall_m !== (d_req && !d_ack)) inv_viol++;
            if (i_ack) begin
                if (!i_out) ack_viol++;
                else begin
                    check("rand_i_rdata", i_rdata, pattern(i_cur));
                    i_out = 0; i_done++;
                end
            end
            if (d_ack) begin
                if (!d_out) ack_viol++;
                else begin
                    if (d_cur_we) begin
                        dref[d_cur] = d_cur_wd;
                        check("rand_store_keeps_rdata", d_rdata, last_load);
                    end else begin
                        last_load = dref.exists(d_cur) ? dref[d_cur] : pattern(d_cur);
                        check("rand_load_rdata", d_rdata, last_load);
                    end
                    d_out = 0; d_done++;
                end
            end
            if (i_out) begin
                i_age++;
                if (i_age == 40) age_viol++;
            end else if (c < 400 && $urandom_range(0, 2) == 0) begin
                i_cur = 32'($urandom_range(0, 63)) << 2;
                i_req = 1; i_addr = i_cur; i_out = 1; i_age = 0;
            end else i_req = 0;
            if (d_out) begin
                d_age++;
                if (d_age == 40) age_viol++;
            end else if (c < 400 && $urandom_range(0, 2) == 0) begin
                d_cur    = 32'h400 + (32'($urandom_range(0, 7)) << 2);
                d_cur_we = 1'($urandom_range(0, 1));
                d_cur_wd = $urandom;
                d_req = 1; d_we = d_cur_we; d_addr = d_cur; d_wdata = d_cur_wd;
                d_out = 1; d_age = 0;
            end else d_req = 0;
            if (c >= 400 && !i_out && !d_out) break;
        end
        rand_mode = 0;
        i_req = 0; d_req = 0;
        check("rand_drained", {i_out, d_out}, 2'b00);
        check("rand_invariants", inv_viol, 0);
        check("rand_spurious_acks", ack_viol, 0);
        check("rand_latency_bound", age_viol, 0);
        check("rand_i_activity", i_done > 20, 1'b1);
        check("rand_d_activity", d_done > 20, 1'b1);
        check("rand_no_timeout", timeout_err, 1'b0);
        repeat (3) @(posedge clk);

        // Timeout: memory never answers an I fetch
        never_ready = 1;
        @(posedge clk); #1;
        i_req = 1; i_addr = 32'h10C;
        ack_cyc = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (i_ack) begin
                ack_cyc = c;
                check("to_i_rdata", i_rdata, 32'h0);
                check("to_m_req", m_req, 1'b0);
                check("to_flag", timeout_err, 1'b1);
                i_req = 0;
                break;
            end
        end
        check("to_ack_cycle", ack_cyc, 1 + MW);
        never_ready = 0;
        @(posedge clk); #1;
        d_req = 1; d_we = 0; d_addr = 32'h300;
        nd = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (d_ack) begin
                nd++;
                d_req = 0;
                break;
            end
        end
        check("to_after_ack", nd, 1);
        check("to_after_rdata", d_rdata, 32'h12345678);
        check("to_sticky", timeout_err, 1'b1);
        repeat (2) @(posedge clk);

        // Reset asserted while BUSY_D
        never_ready = 1;
        @(posedge clk); #1;
        d_req = 1; d_we = 0; d_addr = 32'h300;
        @(posedge clk); #3;
        check("rst_pre_busy", {busy, m_req}, 2'b11);
        reset = 1'b1;
        #1;
        check("rst_async_ctl", {m_req, m_we, busy, timeout_err}, 4'b0000);
        @(posedge clk);
        @(negedge clk);
        never_ready = 0;
        reset = 1'b0;
        nd = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (d_ack) begin
                nd++;
                d_req = 0;
            end
        end
        check("rst_one_ack", nd, 1);
        check("rst_d_rdata", d_rdata, 32'h12345678);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency memory between the pipeline's instruction-fetch requester (I) and the MEM-stage data requester (D).
- Grants one requester at a time and drives the memory request. When the memory completes, it returns read data and pulses an ack to the granted requester.
- Exports per-stage stall signals that the pipeline stall/flush logic ORs with the data-hazard stall.
- Sits between the IF/MEM stages and the unified instruction/data memory.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_WAIT, 15, maximum wait cycles for m_ready before timeout; 0 disables the timeout

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- i_req  in  1  fetch request; held with i_addr until i_ack
- i_addr  in  ADDR_W  fetch address
- i_ack  out  1  one-cycle completion pulse to fetch
- i_rdata  out  DATA_W  fetched word; valid from the i_ack cycle, held until the next I completion
- d_req  in  1  data request; held with d_we, d_addr, d_wdata until d_ack
- d_we  in  1  1 = store (STR), 0 = load (LDR)
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_ack  out  1  one-cycle completion pulse to the data stage
- d_rdata  out  DATA_W  load data; updated only on load completion
- m_req  out  1  memory request
- m_we  out  1  memory write enable; only ever high while m_req is high
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_rdata  in  DATA_W  memory read data, valid with m_ready
- m_ready  in  1  memory completion; ignored while m_req = 0
- stall_f  out  1  i_req & ~i_ack (combinational)
- stall_m  out  1  d_req & ~d_ack (combinational)
- busy  out  1  a transaction is in flight (state != IDLE)
- timeout_err  out  1  sticky timeout flag

Behaviour:
- Reset values: all outputs 0, state IDLE, last_grant = I (so D wins the first tie), wait counter 0.
- Reset mid-transaction: m_req/m_we drop asynchronously. The in-flight transaction is abandoned and no ack is issued after reset releases.
- States: IDLE, BUSY_I, BUSY_D.
- Arbitration happens at every edge where the state is IDLE, and at every completion edge.
  - Eligible requesters are x_req & ~x_ack; a requester is masked during its own ack cycle.
  - The requester that is completing at that edge is also excluded.
  - If only one requester is eligible, it is granted.
  - If both are eligible, grant the one that is not last_grant (round-robin).
- Grant edge: register m_req = 1, m_addr, m_we (0 for I), and m_wdata (0 for I). Set last_grant and move to BUSY_x.
- m_addr, m_we and m_wdata stay stable while in BUSY_x.
- Completion edge (BUSY_x with m_ready = 1):
  - capture m_rdata into x_rdata (skipped for a D store);
  - x_ack = 1 for exactly one cycle;
  - re-arbitrate at the same edge, so back-to-back transactions have no bubble;
  - m_req goes to 0 if nothing is granted.
- Latency: request seen in cycle 0, m_req high in cycle 1, ack in cycle 2 at the earliest. Each additional cycle with m_ready low adds one cycle.
- Timeout:
  - The wait counter increments on every BUSY cycle with m_ready = 0 and clears on each grant.
  - When the counter reaches MAX_WAIT (with MAX_WAIT != 0): set timeout_err (sticky until reset), pulse x_ack with x_rdata = 0, drop m_req, return to IDLE.
- Simultaneous m_ready and timeout at the same edge: m_ready wins (normal completion).
- A requester dropping req while granted is a protocol violation. The transaction still completes and the ack is still issued.

Decomposition:
- Package arm_mem_pkg: state encoding (IDLE = 2'd0, BUSY_I = 2'd1, BUSY_D = 2'd2); grant constants GRANT_I = 1'b0, GRANT_D = 1'b1.
- Sub-module mem_wait_timer: counter with clear and enable inputs, MAX_WAIT compare, `expired` output.

Test Plan:
- I read, memory ready immediately: i_req = 1, i_addr = 0x100, m_rdata = 0xE3A01005 → m_req/m_addr = 0x100 in cycle 1; i_ack and i_rdata = 0xE3A01005 in cycle 2; stall_f = 1 in cycles 0–1.
- i_req (0x104) and d_req store (0x200, wdata 0xDEADBEEF) together after reset → D granted first with m_we = 1 and m_wdata = 0xDEADBEEF; I granted at the D completion edge with no bubble; d_rdata unchanged.
- Both requesters held high for 6 transactions → grant order D, I, D, I, D, I; each ack exactly one cycle long.
- m_ready held low for 3 cycles during a D load at 0x300 → m_addr stable throughout; d_ack 3 cycles later than the minimum latency; d_rdata equals m_rdata at the m_ready cycle.
- MAX_WAIT = 4, m_ready never asserted → after 4 wait cycles: timeout_err = 1, i_ack pulse with i_rdata = 0, m_req = 0; timeout_err stays set across later transactions until reset.
- reset asserted in BUSY_D → m_req = 0 and busy = 0 immediately (asynchronous); after release with d_req still high, a fresh grant follows and exactly one d_ack is issued.
